// File: rtl/pulse_cmd_loader_if.sv
// Byte-stream ingress and show-ahead FIFO read side of the pulse command loader.
// Latency: none (wires only).
// Backpressure: s_byte_ready gates the byte stream; fifo_empty gates fifo_read.
// Ports: s_byte_data/s_byte_valid/s_byte_ready - host byte handshake;
//        fifo_empty/fifo_data/fifo_read/fifo_level - pulse_gen facing FIFO side.
interface pulse_cmd_loader_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          s_byte_data;
  logic                s_byte_valid;
  logic                s_byte_ready;
  logic                fifo_empty;
  logic [31:0]         fifo_data;
  logic                fifo_read;
  logic [DEPTH_LOG2:0] fifo_level;

  // Host and pulse_gen side
  modport master (
    output s_byte_data, s_byte_valid, fifo_read,
    input  s_byte_ready, fifo_empty, fifo_data, fifo_level
  );

  // Loader side
  modport slave (
    input  s_byte_data, s_byte_valid, fifo_read,
    output s_byte_ready, fifo_empty, fifo_data, fifo_level
  );
endinterface

// File: rtl/pulse_cmd_loader.sv
// Assembles host bytes (MSB first) into 32-bit pulse commands, drops illegal codes, buffers legal ones.
// Latency: 4th byte accepted at edge N -> word visible on fifo_data after edge N; pop visible after its edge.
// Backpressure: s_byte_ready drops only while the 4th byte waits on a full FIFO; the idle timeout is frozen then.
// Ports: clk, rst (async, active-low); bus (slave modport: byte handshake + FIFO read side);
//        err_clr (sync clear of counters); err_bad_cmd / err_timeout (saturating 8-bit error counts).
module pulse_cmd_loader #(
  parameter int DEPTH_LOG2     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  pulse_cmd_loader_if.slave  bus,
  input  logic               err_clr,
  output logic [7:0]         err_bad_cmd,
  output logic [7:0]         err_timeout
);

  localparam logic [15:0]         TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [DEPTH_LOG2:0] PTR_MSB   = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic                  run_q;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           word_q, word_d;
  logic [15:0]           tmo_q, tmo_d;
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]            bad_q, bad_d;
  logic [7:0]            tmo_err_q, tmo_err_d;
  logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];

  logic fifo_full, fifo_empty_w, stall, ready, accept, last;
  logic cmd_legal, push, drop, pop, tmo_fire;

  assign fifo_full    = (wr_ptr_q ^ rd_ptr_q) == PTR_MSB;
  assign fifo_empty_w = wr_ptr_q == rd_ptr_q;
  // Only the completing byte needs a free slot; earlier bytes just sit in word_q.
  assign stall        = (idx_q == 2'd3) && fifo_full;
  assign ready        = run_q && !stall;
  assign accept       = bus.s_byte_valid && ready;
  assign last         = accept && (idx_q == 2'd3);
  assign cmd_legal    = word_q[23:16] <= 8'd2;
  assign push         = last && cmd_legal;
  assign drop         = last && !cmd_legal;
  assign pop          = bus.fifo_read && !fifo_empty_w;

  always_comb begin
    tmo_d    = tmo_q;
    tmo_fire = 1'b0;
    if (accept || idx_q == 2'd0) begin
      tmo_d = 16'd0;
    end else if (!stall) begin
      if (tmo_q + 16'd1 == TMO_LIMIT) begin
        tmo_fire = 1'b1;
        tmo_d    = 16'd0;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (tmo_fire) begin
      idx_d = 2'd0;
    end else if (accept) begin
      idx_d  = idx_q + 2'd1;
      // Shift register: after three bytes word_q holds byte0..byte2, stale bytes fall out.
      word_d = {word_q[15:0], bus.s_byte_data};
    end
  end

  assign wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop};

  always_comb begin
    bad_d     = bad_q;
    tmo_err_d = tmo_err_q;
    if (err_clr) begin
      bad_d     = 8'd0;
      tmo_err_d = 8'd0;
    end else begin
      if (drop && bad_q != 8'hFF)         bad_d     = bad_q + 8'd1;
      if (tmo_fire && tmo_err_q != 8'hFF) tmo_err_d = tmo_err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q     <= 1'b0;
      idx_q     <= 2'd0;
      word_q    <= 24'd0;
      tmo_q     <= 16'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      bad_q     <= 8'd0;
      tmo_err_q <= 8'd0;
    end else begin
      run_q     <= 1'b1;
      idx_q     <= idx_d;
      word_q    <= word_d;
      tmo_q     <= tmo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      bad_q     <= bad_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {word_q, bus.s_byte_data};
  end

  assign bus.s_byte_ready = ready;
  assign bus.fifo_empty   = fifo_empty_w;
  assign bus.fifo_data    = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign bus.fifo_level   = wr_ptr_q - rd_ptr_q;
  assign err_bad_cmd      = bad_q;
  assign err_timeout      = tmo_err_q;

endmodule

// File: tb/tb_pulse_cmd_loader.sv
// Directed bench for pulse_cmd_loader: assembly, illegal-code drop, timeout, full stall, streaming, saturation, reset.
// Latency: checks sampled 1 time unit after the active clock edge.
// Backpressure: byte sends wait (bounded) on s_byte_ready.
module tb_pulse_cmd_loader;

  logic       clk;
  logic       rst;
  logic       err_clr;
  logic [7:0] err_bad_cmd;
  logic [7:0] err_timeout;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] w;

  pulse_cmd_loader_if #(.DEPTH_LOG2(4)) bus ();

  pulse_cmd_loader #(.DEPTH_LOG2(4), .TIMEOUT_CYCLES(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_clr     (err_clr),
    .err_bad_cmd (err_bad_cmd),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.s_byte_data  = b;
    bus.s_byte_valid = 1'b1;
    while (bus.s_byte_ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.s_byte_ready !== 1'b1) check("ready_wait", {31'd0, bus.s_byte_ready}, 32'd1);
    @(posedge clk); #1;
    bus.s_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] v);
    send_byte(v[31:24]);
    send_byte(v[23:16]);
    send_byte(v[15:8]);
    send_byte(v[7:0]);
  endtask

  task automatic pop_one();
    bus.fifo_read = 1'b1;
    @(posedge clk); #1;
    bus.fifo_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst              = 1'b0;
    err_clr          = 1'b0;
    bus.s_byte_data  = 8'h00;
    bus.s_byte_valid = 1'b0;
    bus.fifo_read    = 1'b0;

    // Reset state
    #1;
    check("rst_ready", {31'd0, bus.s_byte_ready}, 32'd0);
    check("rst_empty", {31'd0, bus.fifo_empty}, 32'd1);
    check("rst_level", {27'd0, bus.fifo_level}, 32'd0);
    check("rst_bad", {24'd0, err_bad_cmd}, 32'd0);
    check("rst_tmo", {24'd0, err_timeout}, 32'd0);
    idle(3);
    rst = 1'b1;
    #1;
    check("ready_before_run", {31'd0, bus.s_byte_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_after_run", {31'd0, bus.s_byte_ready}, 32'd1);

    // Basic word
    send_word(32'h01000503);
    check("w1_empty", {31'd0, bus.fifo_empty}, 32'd0);
    check("w1_data", bus.fifo_data, 32'h01000503);
    check("w1_level", {27'd0, bus.fifo_level}, 32'd1);
    pop_one();
    check("w1_pop_empty", {31'd0, bus.fifo_empty}, 32'd1);
    check("w1_pop_level", {27'd0, bus.fifo_level}, 32'd0);

    // Illegal command dropped, next legal word kept
    send_word(32'h07112233);
    check("bad_cnt", {24'd0, err_bad_cmd}, 32'd1);
    check("bad_level", {27'd0, bus.fifo_level}, 32'd0);
    send_word(32'h02001000);
    check("legal_level", {27'd0, bus.fifo_level}, 32'd1);
    check("legal_data", bus.fifo_data, 32'h02001000);
    pop_one();

    // 1023 idle cycles mid-word: no timeout, bytes merge
    send_byte(8'h00);
    send_byte(8'hAA);
    idle(1023);
    send_byte(8'h00);
    send_byte(8'h00);
    check("tmo1023_cnt", {24'd0, err_timeout}, 32'd0);
    check("tmo1023_data", bus.fifo_data, 32'h00AA0000);
    pop_one();

    // 1024 idle cycles mid-word: partial discarded
    send_byte(8'h00);
    send_byte(8'hAA);
    idle(1024);
    check("tmo1024_cnt", {24'd0, err_timeout}, 32'd1);
    send_word(32'h00000000);
    check("tmo_clean_data", bus.fifo_data, 32'h00000000);
    check("tmo_clean_level", {27'd0, bus.fifo_level}, 32'd1);
    pop_one();
    check("tmo_clean_empty", {31'd0, bus.fifo_empty}, 32'd1);

    // Fill to 16 and stall the 17th word on its last byte
    for (int i = 0; i < 16; i++) send_word(32'h01000000 + i);
    check("full_level", {27'd0, bus.fifo_level}, 32'd16);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    bus.s_byte_data  = 8'hAA;
    bus.s_byte_valid = 1'b1;
    check("stall_ready", {31'd0, bus.s_byte_ready}, 32'd0);
    idle(1100);
    check("stall_ready_late", {31'd0, bus.s_byte_ready}, 32'd0);
    check("stall_no_tmo", {24'd0, err_timeout}, 32'd1);
    check("stall_level", {27'd0, bus.fifo_level}, 32'd16);
    check("stall_head", bus.fifo_data, 32'h01000000);
    pop_one();
    check("unstall_ready", {31'd0, bus.s_byte_ready}, 32'd1);
    check("unstall_level", {27'd0, bus.fifo_level}, 32'd15);
    @(posedge clk); #1;
    bus.s_byte_valid = 1'b0;
    check("refill_level", {27'd0, bus.fifo_level}, 32'd16);
    for (int i = 1; i < 16; i++) begin
      check("readback", bus.fifo_data, 32'h01000000 + i);
      pop_one();
    end
    check("readback_17th", bus.fifo_data, 32'h010000AA);
    pop_one();
    check("drained_empty", {31'd0, bus.fifo_empty}, 32'd1);

    // Concurrent read/write around a level of 5
    for (int i = 0; i < 5; i++) begin
      w = 32'h02000100 + i;
      send_word(w);
      exp_q.push_back(w);
    end
    for (int k = 0; k < 20; k++) begin
      w = 32'h01003000 + k;
      check("stream_head", bus.fifo_data, exp_q.pop_front());
      bus.fifo_read = 1'b1;
      send_byte(w[31:24]);
      bus.fifo_read = 1'b0;
      check("stream_level_lo", {27'd0, bus.fifo_level}, 32'd4);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
      exp_q.push_back(w);
      check("stream_level_hi", {27'd0, bus.fifo_level}, 32'd5);
    end
    for (int i = 0; i < 5; i++) begin
      check("stream_drain", bus.fifo_data, exp_q.pop_front());
      pop_one();
    end
    bus.fifo_read = 1'b1;
    idle(3);
    bus.fifo_read = 1'b0;
    check("rd_empty_level", {27'd0, bus.fifo_level}, 32'd0);
    check("rd_empty_flag", {31'd0, bus.fifo_empty}, 32'd1);
    send_word(32'h02ABCDEF);
    check("rd_empty_push_level", {27'd0, bus.fifo_level}, 32'd1);
    check("rd_empty_push_data", bus.fifo_data, 32'h02ABCDEF);
    pop_one();

    // Saturation and clear priority
    for (int i = 0; i < 300; i++) send_word(32'h05000000 + i);
    check("bad_sat", {24'd0, err_bad_cmd}, 32'd255);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h00);
    err_clr = 1'b1;
    send_byte(8'h00);
    err_clr = 1'b0;
    check("clr_bad", {24'd0, err_bad_cmd}, 32'd0);
    check("clr_tmo", {24'd0, err_timeout}, 32'd0);
    check("clr_level", {27'd0, bus.fifo_level}, 32'd0);

    // Reset mid-word with buffered data and a nonzero error count
    send_word(32'h01111111);
    send_word(32'h09000000);
    send_byte(8'h02);
    send_byte(8'h33);
    check("pre_rst_level", {27'd0, bus.fifo_level}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_level", {27'd0, bus.fifo_level}, 32'd0);
    check("mid_rst_empty", {31'd0, bus.fifo_empty}, 32'd1);
    check("mid_rst_ready", {31'd0, bus.s_byte_ready}, 32'd0);
    check("mid_rst_bad", {24'd0, err_bad_cmd}, 32'd0);
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    send_word(32'h01020304);
    check("post_rst_data", bus.fifo_data, 32'h01020304);
    check("post_rst_level", {27'd0, bus.fifo_level}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_cmd_loader.md
# pulse_cmd_loader

Upstream feeder for `pulse_gen`. It accepts a host byte stream, for example from the UART/AXIS bridge, over a valid/ready handshake. It assembles each four bytes, MSB first, into one 32-bit pulse command, checks the command code, and buffers legal commands in an internal show-ahead FIFO. The FIFO read side connects directly to `pulse_gen`'s `fifo_empty` / `fifo_data` / `fifo_read` inputs.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 words (16).
- `TIMEOUT_CYCLES`, default 1024: idle cycles allowed mid-word before the partial word is discarded. Legal range is 1..65535.
- `clk` in 1: system clock, the RFSoC fabric clock shared with `pulse_gen`.
- `rst` in 1: reset, asynchronous, active-low.
- `s_byte_data` in 8: host command byte.
- `s_byte_valid` in 1: byte valid.
- `s_byte_ready` out 1: loader can accept a byte.
- `fifo_empty` out 1: no buffered command.
- `fifo_data` out 32: oldest buffered command. Valid whenever `fifo_empty`=0.
- `fifo_read` in 1: pop strobe from `pulse_gen`.
- `fifo_level` out DEPTH_LOG2+1: number of buffered words, 0..2^DEPTH_LOG2.
- `err_clr` in 1: synchronous clear of all error counters.
- `err_bad_cmd` out 8: count of words dropped for an illegal command code. Saturates at 255.
- `err_timeout` out 8: count of partial words discarded by timeout. Saturates at 255.

## Operation
- Word format, as consumed by `pulse_gen`:
  - [31:24] command.
  - [23:8] coarse.
  - [7:0] fine.
  - For set-period, [23:0] is the period.
- Legal commands: 0 = reset clock, 1 = send pulse, 2 = set period. Command codes 3..255 are illegal.
- Assembler: byte index `idx` runs 0..3. The byte at idx 0 lands in [31:24], idx 1 in [23:16], idx 2 in [15:8], idx 3 in [7:0].
- Handshake: a byte is accepted on a rising edge with `s_byte_valid`=1 and `s_byte_ready`=1. `idx` advances on acceptance and wraps 3→0.
- On acceptance at idx 3 the word completes in that same edge:
  - Illegal command: the word is dropped and `err_bad_cmd` increments.
  - Legal command: the word is written to the FIFO.
- `s_byte_ready` = `run` AND NOT(`idx`==3 AND FIFO full).
  - `run` is a flag that clears in reset and sets on the first clock edge after reset is released.
  - A pop in the same cycle does not raise ready; ready rises the cycle after the level drops.
- Timeout counter (16 bit):
  - Clears on every accepted byte and whenever `idx`==0.
  - Counts each cycle with `idx`≠0, no acceptance, and not stalled by a full FIFO at `idx`==3.
  - On reaching TIMEOUT_CYCLES: `idx`←0, partial bytes discarded, `err_timeout` increments, counter clears.
- FIFO:
  - Circular buffer with DEPTH_LOG2+1-bit read and write pointers. Full when the MSBs differ and the low bits are equal.
  - `fifo_data` = mem[rd_ptr[DEPTH_LOG2-1:0]], read combinationally (show-ahead).
  - Pop on `fifo_read`=1 AND `fifo_empty`=0. A `fifo_read` while empty is ignored.
  - A simultaneous push and pop on a non-empty FIFO leaves `fifo_level` unchanged.
  - A push into an empty FIFO with `fifo_read`=1 in the same cycle pushes only; the pop is ignored because the FIFO was empty at that edge.
- Error counters saturate at 255. `err_clr` has priority over an increment in the same cycle; the result is 0.
- Reset values:
  - `idx`=0, timeout counter 0, pointers 0, `run`=0.
  - `fifo_empty`=1, `fifo_level`=0, `s_byte_ready`=0.
  - `err_bad_cmd`=0, `err_timeout`=0.
  - `fifo_data` is don't-care while empty.
- Reset mid-word or with the FIFO non-empty discards all partial and buffered data.

## Timing
- Push latency: 4th byte accepted at edge N → `fifo_empty`=0 and `fifo_data` valid from edge N, i.e. in cycle N+1. `fifo_level` updates at the same edge.
- Pop: `fifo_read` sampled at edge M → the next entry appears on `fifo_data` after edge M.
- Maximum throughput is one byte per cycle, which is one command per 4 cycles. Pop rate is up to one per cycle.
- `s_byte_ready` is combinational from registered state only, with no path from `s_byte_valid`.
- Flags `fifo_empty` and `fifo_level` are registered or derived from registered pointers only; there is no combinational path from `fifo_read`.

## Test plan
- Reset release, then bytes 01 00 05 03 → `s_byte_ready`=0 during reset and 1 one cycle after release. `fifo_empty` falls after the 4th byte edge, `fifo_data`=0x01000503, `fifo_level`=1. Pulse `fifo_read` once → `fifo_empty`=1, `fifo_level`=0.
- Bytes 07 11 22 33, then 02 00 10 00 → first word dropped with `err_bad_cmd`=1; FIFO holds only 0x02001000.
- Send bytes 00 AA, idle for TIMEOUT_CYCLES, then 00 00 00 00 → `err_timeout`=1 and `fifo_data`=0x00000000 (the partial AA is not merged). With 1023 idle cycles and TIMEOUT_CYCLES=1024 there is no timeout.
- Push 16 legal words with `fifo_read`=0, then offer a 17th → `fifo_level`=16. `s_byte_ready` drops at idx 3 of the 17th word and the timeout counter does not run while stalled. After one pop, ready returns one cycle later, the word is pushed, and the 16 entries read back in order.
- With the FIFO holding 5 words, read and write concurrently for 20 commands → `fifo_level` stays within 4..5, no loss, order preserved. `fifo_read` on an empty FIFO leaves pointers unchanged.
- Drive 300 illegal words, then `err_clr` together with a 301st illegal word → counter holds at 255 and then reads 0. Asserting `rst` mid-word clears everything, and the next 4 bytes form a clean word.
